// File: rtl/vec_result_writeback.sv
// vec_result_writeback: captures the adder result on a done rising edge and writes
// its 16-bit lanes to consecutive addresses with a ready/valid stall, keeping sticky
// overflow/overrun status. Optional macro VWB_SKIP_ZERO_EN skips +0.0 lanes.
module vec_result_writeback #(
    parameter int ADDR_W = 8,
    parameter int LANES  = 16
) (
    input  logic                  Clk1,
    input  logic                  Rst_n,
    input  logic [16*LANES-1:0]   SumV,
    input  logic                  V,
    input  logic                  done,
    input  logic [ADDR_W-1:0]     BaseAddr,
    input  logic                  WrRdy,
    input  logic                  ovf_clr,
    output logic                  WrEn,
    output logic [ADDR_W-1:0]     WrAddr,
    output logic [15:0]           WrData,
    output logic                  busy,
    output logic                  wb_done,
    output logic                  ovf_sticky,
    output logic                  overrun
);
    localparam int CW = $clog2(LANES);
    typedef enum logic [1:0] {IDLE, WRITE, FIN} state_t;
    state_t              state;
    logic [16*LANES-1:0] res;
    logic [ADDR_W-1:0]   base;
    logic [CW-1:0]       cnt;
    logic                act;
    logic                done_q;
    logic                capture;
    logic                adv;
    logic                last;
    logic [CW-1:0]       nxt;
    logic [15:0]         nxt_data;
    logic                nxt_wr;

    // act marks a lane on the port (written or skipped); adv is the moment it retires
    always_comb begin
        capture  = done & ~done_q;
        adv      = act & (WrRdy | ~WrEn);
        last     = cnt == CW'(LANES - 1);
        nxt      = act ? cnt + CW'(1) : cnt;
        nxt_data = res[{nxt, 4'b0000} +: 16];
`ifdef VWB_SKIP_ZERO_EN
        nxt_wr   = nxt_data != 16'h0000;
`else
        nxt_wr   = 1'b1;
`endif
    end

    // capture/serialise FSM with registered write port and sticky status flags
    always_ff @(posedge Clk1 or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            res        <= '0;
            base       <= '0;
            cnt        <= '0;
            act        <= 1'b0;
            done_q     <= 1'b0;
            WrEn       <= 1'b0;
            WrAddr     <= '0;
            WrData     <= '0;
            busy       <= 1'b0;
            wb_done    <= 1'b0;
            ovf_sticky <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            done_q     <= done;
            wb_done    <= state == FIN;
            ovf_sticky <= (capture & V & (state != WRITE)) | (ovf_sticky & ~ovf_clr);
            overrun    <= ~ovf_clr & (overrun | (capture & (state == WRITE)));
            case (state)
                WRITE: begin
                    if (!act || adv) begin
                        if (act && last) begin
                            state <= FIN;
                            act   <= 1'b0;
                            WrEn  <= 1'b0;
                            busy  <= 1'b0;
                        end else begin
                            cnt    <= nxt;
                            act    <= 1'b1;
                            WrEn   <= nxt_wr;
                            WrAddr <= base + ADDR_W'(nxt);
                            WrData <= nxt_data;
                        end
                    end
                end
                default: begin
                    if (capture) begin
                        res   <= SumV;
                        base  <= BaseAddr;
                        cnt   <= '0;
                        act   <= 1'b0;
                        busy  <= 1'b1;
                        state <= WRITE;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
